fc_score_collector: RTL

Upstream driver for the FC-stage argmax comparator. Accepts the final FC layer's class scores as a serial valid/ready stream. Buffers one full vector of `N_CLASSES` signed scores and presents it to the comparator as a parallel array. Runs the comparator's reset/enable/done handshake, then reports the winning class index downstream as a one-cycle pulse.

---
 rtl/fc_pkg.sv | 23 ++
 rtl/score_buffer.sv | 38 +++
 rtl/fc_score_collector.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared constants and state type for the FC score collector
//                and its score buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int N_CLASSES = 10;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 4;

    // Collector control states
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COMPARE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/score_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : score_buffer
//  Description : N_CLASSES x DATA_W register file. One write port addressed
//                by class index, all entries exposed as one flattened vector
//                (entry k at bits [k*DATA_W +: DATA_W]). Async active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_buffer #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  logic [IDX_W-1:0]              i_wr_idx,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic [N_CLASSES*DATA_W-1:0]   o_cmp_arr
);

    for (genvar k = 0; k < N_CLASSES; k++) begin : g_entry
        logic [DATA_W-1:0] r_entry;

        // Entry k captures the write data when addressed
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_entry <= '0;
            end else if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                r_entry <= i_wr_data;
            end
        end

        assign o_cmp_arr[k*DATA_W +: DATA_W] = r_entry;
    end

endmodule
`default_nettype wire

// File: rtl/fc_score_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fc_score_collector
//  Description : Collects one vector of class scores from a serial
//                valid/ready stream, hands it to the argmax comparator as a
//                parallel array, runs the comparator clear/enable/done
//                handshake and pulses the winning class index downstream.
//                Optional feature macro: FC_COLLECT_TIMEOUT_EN (bounds the
//                wait for cmp_done to TIMEOUT cycles and flags a timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_score_collector #(
    parameter int N_CLASSES = fc_pkg::N_CLASSES,
    parameter int DATA_W    = fc_pkg::DATA_W,
    parameter int IDX_W     = fc_pkg::IDX_W,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [N_CLASSES*DATA_W-1:0]   cmp_arr,
    output logic                          cmp_reset,
    output logic                          cmp_enable,
    input  logic                          cmp_done,
    input  logic [IDX_W-1:0]              cmp_result,
    output logic                          class_valid,
    output logic [IDX_W-1:0]              class_idx,
    output logic                          timeout_err
);

    import fc_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_class_idx;
    logic              w_accept;
    logic              w_last;
    logic              w_expire;

    assign w_accept    = in_valid && in_ready;
    assign w_last      = (r_cnt == IDX_W'(N_CLASSES - 1));
    assign class_idx   = r_class_idx;

`ifdef FC_COLLECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;
    logic          r_timeout_err;

    // Cycles spent in COMPARE without a done; cleared everywhere else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (r_state == ST_COMPARE && !cmp_done) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    // A done on the expiry edge wins over the timeout
    assign w_expire = (r_state == ST_COMPARE) && !cmp_done &&
                      (r_tmo == TW'(TIMEOUT - 1));

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT > 0);
    assign w_expire     = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore handshake outputs; in_ready is held low in reset
    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        cmp_reset   = 1'b0;
        cmp_enable  = 1'b0;
        class_valid = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                in_ready = reset;
                if (w_accept && w_last) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cmp_reset = 1'b1;
                w_next    = ST_COMPARE;
            end
            ST_COMPARE: begin
                cmp_enable = 1'b1;
                if (cmp_done || w_expire) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                class_valid = 1'b1;
                w_next      = ST_COLLECT;
            end
            default: begin
                w_next = ST_COLLECT;
            end
        endcase
    end

    // Beat counter: advances per accepted beat, rewinds after each report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_REPORT) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result capture: comparator index on done, all-ones on timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_class_idx <= '0;
        end else if (r_state == ST_COMPARE && cmp_done) begin
            r_class_idx <= cmp_result;
        end else if (w_expire) begin
            r_class_idx <= '1;
        end
    end

    score_buffer #(
        .N_CLASSES (N_CLASSES),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (reset),
        .i_wr_en   (w_accept),
        .i_wr_idx  (r_cnt),
        .i_wr_data (in_data),
        .o_cmp_arr (cmp_arr)
    );

endmodule
`default_nettype wire
